// File: rtl/led_string_pkg.sv
// Shared definitions for the LED-string SPI protocol: frame types, frame layout
// and the receive-side frame classifier.
package led_string_pkg;

   localparam int          FRAME_BITS = 32;
   localparam logic [2:0]  LED_HEADER = 3'b111;

   typedef enum logic [1:0] {
      INPUT_TYPE_START = 2'd0,
      INPUT_TYPE_LED   = 2'd1,
      INPUT_TYPE_END   = 2'd2
   } input_type_e;

   typedef enum logic [1:0] {
      CLS_START,
      CLS_LED,
      CLS_END,
      CLS_BAD
   } frame_class_e;

   typedef struct packed {
      logic [2:0] header;
      logic [4:0] brightness;
      logic [7:0] blue;
      logic [7:0] green;
      logic [7:0] red;
   } led_frame_t;

   // All-zeros and all-ones are tested before the LED header, so a full-white
   // LED frame at maximum brightness reads as END.
   function automatic frame_class_e classify_frame(input logic [FRAME_BITS-1:0] f);
      led_frame_t lf;
      lf = led_frame_t'(f);
      if (f == '0)
         return CLS_START;
      else if (f == '1)
         return CLS_END;
      else if (lf.header == LED_HEADER)
         return CLS_LED;
      else
         return CLS_BAD;
   endfunction

endpackage

// File: rtl/undoled_sync.sv
// Two-flop synchroniser for sck/mosi with a registered sck rising-edge strobe;
// mosi_s is aligned to the strobe and taken from the same synchronised stage.
module undoled_sync (
   input  logic clk,
   input  logic reset,
   input  logic sck,
   input  logic mosi,
   output logic sck_rise,
   output logic mosi_s
);

   logic sck_s1_q,  sck_s2_q,  sck_prev_q;
   logic mosi_s1_q, mosi_s2_q;
   logic rise_q,    mosi_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sck_s1_q   <= 1'b0;
         sck_s2_q   <= 1'b0;
         sck_prev_q <= 1'b0;
         mosi_s1_q  <= 1'b0;
         mosi_s2_q  <= 1'b0;
         rise_q     <= 1'b0;
         mosi_q     <= 1'b0;
      end else begin
         sck_s1_q   <= sck;
         sck_s2_q   <= sck_s1_q;
         sck_prev_q <= sck_s2_q;
         mosi_s1_q  <= mosi;
         mosi_s2_q  <= mosi_s1_q;
         rise_q     <= sck_s2_q & ~sck_prev_q;
         mosi_q     <= mosi_s2_q;
      end
   end

   assign sck_rise = rise_q;
   assign mosi_s   = mosi_q;

endmodule

// File: rtl/undoled.sv
// Receive-side LED-string SPI decoder: reassembles 32-bit frames from the
// synchronised sck/mosi and reports START / LED / END frames with LED counters.
module undoled
   import led_string_pkg::*;
#(
   parameter int IDLE_TIMEOUT = 1024,
   parameter int MAX_LEDS     = 255
) (
   input  logic       undoled_clk,
   input  logic       undoled_reset,
   input  logic       sck,
   input  logic       mosi,
   output logic       frame_valid,
   output logic [1:0] frame_type,
   output logic [4:0] brightness,
   output logic [7:0] blue_out,
   output logic [7:0] green_out,
   output logic [7:0] red_out,
   output logic [7:0] led_index,
   output logic [7:0] led_count,
   output logic       frame_error
);

   localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

   logic sck_rise;
   logic mosi_s;

   undoled_sync u_sync (
      .clk      (undoled_clk),
      .reset    (undoled_reset),
      .sck      (sck),
      .mosi     (mosi),
      .sck_rise (sck_rise),
      .mosi_s   (mosi_s)
   );

   logic [FRAME_BITS-1:0] shift_q,       shift_d;
   logic [5:0]            bit_cnt_q,     bit_cnt_d;
   logic [IDLE_W-1:0]     idle_q,        idle_d;
   logic [7:0]            led_cnt_q,     led_cnt_d;
   logic                  string_open_q, string_open_d;
   logic                  frame_valid_q, frame_valid_d;
   logic                  frame_error_q, frame_error_d;
   input_type_e           frame_type_q,  frame_type_d;
   logic [4:0]            bright_q,      bright_d;
   logic [7:0]            blue_q,        blue_d;
   logic [7:0]            green_q,       green_d;
   logic [7:0]            red_q,         red_d;
   logic [7:0]            led_index_q,   led_index_d;
   logic [7:0]            led_count_q,   led_count_d;

   logic [FRAME_BITS-1:0] shift_next;
   led_frame_t            led_fields;

   assign shift_next = {shift_q[FRAME_BITS-2:0], mosi_s};
   assign led_fields = led_frame_t'(shift_next);

   always_comb begin
      shift_d       = shift_q;
      bit_cnt_d     = bit_cnt_q;
      idle_d        = idle_q;
      led_cnt_d     = led_cnt_q;
      string_open_d = string_open_q;
      frame_valid_d = 1'b0;
      frame_error_d = 1'b0;
      frame_type_d  = frame_type_q;
      bright_d      = bright_q;
      blue_d        = blue_q;
      green_d       = green_q;
      red_d         = red_q;
      led_index_d   = led_index_q;
      led_count_d   = led_count_q;

      if (sck_rise) begin
         // An edge always wins over a coincident timeout.
         idle_d  = '0;
         shift_d = shift_next;
         if (bit_cnt_q == 6'(FRAME_BITS - 1)) begin
            bit_cnt_d = '0;
            unique case (classify_frame(shift_next))
               CLS_START: begin
                  frame_valid_d = 1'b1;
                  frame_type_d  = INPUT_TYPE_START;
                  led_index_d   = '0;
                  led_cnt_d     = '0;
                  string_open_d = 1'b1;
               end
               CLS_END: begin
                  frame_valid_d = 1'b1;
                  frame_type_d  = INPUT_TYPE_END;
                  led_count_d   = string_open_q ? led_cnt_q : 8'd0;
                  string_open_d = 1'b0;
               end
               CLS_LED: begin
                  frame_valid_d = 1'b1;
                  frame_type_d  = INPUT_TYPE_LED;
                  bright_d      = led_fields.brightness;
                  blue_d        = led_fields.blue;
                  green_d       = led_fields.green;
                  red_d         = led_fields.red;
                  led_index_d   = led_cnt_q;
                  if (led_cnt_q != 8'(MAX_LEDS))
                     led_cnt_d = led_cnt_q + 8'd1;
               end
               CLS_BAD: begin
                  frame_error_d = 1'b1;
               end
            endcase
         end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
         end
      end else if (idle_q != IDLE_W'(IDLE_TIMEOUT)) begin
         idle_d = idle_q + IDLE_W'(1);
         // Only a partially received frame is worth reporting on timeout.
         if (idle_q == IDLE_W'(IDLE_TIMEOUT - 1) && bit_cnt_q != '0) begin
            bit_cnt_d     = '0;
            frame_error_d = 1'b1;
         end
      end
   end

   always_ff @(posedge undoled_clk) begin
      if (undoled_reset) begin
         shift_q       <= '0;
         bit_cnt_q     <= '0;
         idle_q        <= '0;
         led_cnt_q     <= '0;
         string_open_q <= 1'b0;
         frame_valid_q <= 1'b0;
         frame_error_q <= 1'b0;
         frame_type_q  <= INPUT_TYPE_START;
         bright_q      <= '0;
         blue_q        <= '0;
         green_q       <= '0;
         red_q         <= '0;
         led_index_q   <= '0;
         led_count_q   <= '0;
      end else begin
         shift_q       <= shift_d;
         bit_cnt_q     <= bit_cnt_d;
         idle_q        <= idle_d;
         led_cnt_q     <= led_cnt_d;
         string_open_q <= string_open_d;
         frame_valid_q <= frame_valid_d;
         frame_error_q <= frame_error_d;
         frame_type_q  <= frame_type_d;
         bright_q      <= bright_d;
         blue_q        <= blue_d;
         green_q       <= green_d;
         red_q         <= red_d;
         led_index_q   <= led_index_d;
         led_count_q   <= led_count_d;
      end
   end

   assign frame_valid = frame_valid_q;
   assign frame_error = frame_error_q;
   assign frame_type  = frame_type_q;
   assign brightness  = bright_q;
   assign blue_out    = blue_q;
   assign green_out   = green_q;
   assign red_out     = red_q;
   assign led_index   = led_index_q;
   assign led_count   = led_count_q;

endmodule
